uart_frame_rx: RTL and testbench

Parametrised successor to the single-byte UART terminal path. It drains bytes from the UART receiver FIFO, hunts for a sync byte, assembles a fixed-length multi-byte payload, checks an XOR checksum and enforces an inter-byte timeout. It presents each good frame as one wide word with a one-cycle valid strobe. It sits between the uart driver's rx side and downstream order/decode logic or sseg/LED debug.

---
 rtl/uart_frame_rx.sv | 113 +++++++++++
 tb/tb_uart_frame_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// Frame receiver for the UART rx FIFO: hunts for a sync byte, assembles an NBYTES payload,
// verifies an XOR checksum and aborts frames whose inter-byte gap exceeds TIMEOUT_CYCLES.
module uart_frame_rx #(
    parameter int         NBYTES         = 4,
    parameter logic [7:0] SYNC           = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         CW             = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_empty,
    input  logic [7:0]            r_data,
    output logic                  rd_uart,
    output logic [8*NBYTES-1:0]   frame_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic                  busy,
    output logic [CW-1:0]         good_count,
    output logic [CW-1:0]         err_count
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } state_t;

    state_t               state;
    logic [IW-1:0]        index;
    logic [7:0]           xor_acc;
    logic [TW-1:0]        timer;
    logic [8*NBYTES-1:0]  payload;

    // The FIFO head is popped whenever it holds data, in every state, so the link never stalls.
    assign rd_uart = ~rx_empty & ~reset_n;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state       <= HUNT;
            index       <= '0;
            xor_acc     <= '0;
            timer       <= '0;
            payload     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            busy        <= 1'b0;
            good_count  <= '0;
            err_count   <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (rd_uart && r_data == SYNC) begin
                        state   <= PAYLOAD;
                        busy    <= 1'b1;
                        index   <= '0;
                        xor_acc <= '0;
                        timer   <= '0;
                    end
                end
                PAYLOAD, CHECK: begin
                    if (rd_uart) begin
                        timer <= '0;
                        if (state == PAYLOAD) begin
                            // First payload byte lands in the most significant slot.
                            payload[8*(NBYTES-1-int'(index)) +: 8] <= r_data;
                            xor_acc <= xor_acc ^ r_data;
                            if (index == LAST_IDX) begin
                                state <= CHECK;
                            end else begin
                                index <= index + 1'b1;
                            end
                        end else begin
                            if (r_data == xor_acc) begin
                                frame_data  <= payload;
                                frame_valid <= 1'b1;
                                good_count  <= good_count + 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= 2'b01;
                                err_count <= err_count + 1'b1;
                            end
                            state <= HUNT;
                            busy  <= 1'b0;
                        end
                    end else if (timer == LAST_TICK) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b10;
                        err_count <= err_count + 1'b1;
                        state     <= HUNT;
                        busy      <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: the driver pushes the expected frame outcome for each
// transaction and an independent monitor pops and checks it whenever the DUT strobes.
module tb_uart_frame_rx;

    localparam int         NB   = 4;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TO   = 50;
    localparam int         CW   = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              rx_empty;
    logic [7:0]        r_data;
    logic              rd_uart;
    logic [8*NB-1:0]   frame_data;
    logic              frame_valid;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;
    logic [CW-1:0]     good_count;
    logic [CW-1:0]     err_count;

    uart_frame_rx #(
        .NBYTES(NB),
        .SYNC(SYNC),
        .TIMEOUT_CYCLES(TO),
        .CW(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_empty(rx_empty),
        .r_data(r_data),
        .rd_uart(rd_uart),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .err_code(err_code),
        .busy(busy),
        .good_count(good_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              is_err;
        logic [8*NB-1:0] data;
        logic [1:0]      code;
        int              good;
        int              errs;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              rd_pulses = 0;
    int              bytes_sent = 0;
    int              m_good = 0;
    int              m_err = 0;
    logic [8*NB-1:0] m_last = '0;
    logic [1:0]      m_code = 2'b00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_uart) rd_pulses <= rd_pulses + 1;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b0 && (frame_valid === 1'b1 || frame_err === 1'b1)) begin
            check_output("valid_err_exclusive", {63'd0, frame_valid & frame_err}, 64'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_event: actual valid=%0b err=%0b at cycle %0d required none",
                         frame_valid, frame_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("event_is_err", {63'd0, frame_err}, {63'd0, e.is_err});
                check_output("event_cycle", cyc, e.cyc);
                check_output("frame_data", frame_data, e.data);
                check_output("err_code", err_code, e.code);
                check_output("good_count", good_count, e.good % (1 << CW));
                check_output("err_count", err_count, e.errs % (1 << CW));
                check_output("busy_at_event", {63'd0, busy}, 64'd0);
            end
        end
    end

    task automatic idle(input int n);
        rx_empty = 1'b1;
        repeat (n) begin
            r_data = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        r_data   = b;
        rx_empty = 1'b0;
        @(negedge clk);
        rx_empty = 1'b1;
        r_data   = 8'($urandom);
        bytes_sent++;
    endtask

    task automatic do_reset(input int n, input logic [7:0] pending);
        reset_n  = 1'b1;
        rx_empty = 1'b0;
        r_data   = pending;
        repeat (n) @(negedge clk);
        check_output("reset_rd_uart", {63'd0, rd_uart}, 64'd0);
        check_output("reset_frame_data", frame_data, 64'd0);
        check_output("reset_counts", {good_count, err_count}, 64'd0);
        check_output("reset_err_code", err_code, 64'd0);
        check_output("reset_strobes", {busy, frame_valid, frame_err}, 64'd0);
        rx_empty = 1'b1;
        reset_n  = 1'b0;
        m_good = 0;
        m_err  = 0;
        m_last = '0;
        m_code = 2'b00;
        sb.delete();
    endtask

    // Full frame: SYNC, payload (first byte most significant), checksum byte ck.
    task automatic apply_stimulus(input logic [8*NB-1:0] w, input logic [7:0] ck, input int gmin, input int gmax);
        logic [7:0] x;
        exp_t       e;
        x = 8'h00;
        for (int i = 0; i < NB; i++) x ^= w[8*(NB-1-i) +: 8];
        drive_byte(SYNC);
        check_output("busy_after_sync", {63'd0, busy}, 64'd1);
        for (int i = 0; i < NB; i++) begin
            idle(int'($urandom_range(gmax, gmin)));
            drive_byte(w[8*(NB-1-i) +: 8]);
        end
        idle(int'($urandom_range(gmax, gmin)));
        if (ck == x) begin
            m_good++;
            m_last = w;
            e = '{1'b0, w, m_code, m_good, m_err, cyc + 1};
        end else begin
            m_err++;
            m_code = 2'b01;
            e = '{1'b1, m_last, m_code, m_good, m_err, cyc + 1};
        end
        sb.push_back(e);
        drive_byte(ck);
    endtask

    // SYNC plus k payload bytes, then the line goes quiet long enough to time out.
    task automatic send_truncated(input logic [8*NB-1:0] w, input int k);
        exp_t e;
        drive_byte(SYNC);
        for (int i = 0; i < k; i++) begin
            idle(int'($urandom_range(5, 0)));
            drive_byte(w[8*(NB-1-i) +: 8]);
        end
        m_err++;
        m_code = 2'b10;
        e = '{1'b1, m_last, m_code, m_good, m_err, cyc + TO};
        sb.push_back(e);
        idle(TO + int'($urandom_range(4, 0)));
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            do b = 8'($urandom); while (b == SYNC);
            drive_byte(b);
            idle(int'($urandom_range(2, 0)));
        end
    endtask

    function automatic logic [8*NB-1:0] rand_word();
        logic [8*NB-1:0] w;
        for (int i = 0; i < NB; i++) w[8*i +: 8] = 8'($urandom);
        return w;
    endfunction

    function automatic logic [7:0] xor_of(input logic [8*NB-1:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NB; i++) x ^= w[8*i +: 8];
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        int sel;
        logic [8*NB-1:0] w;
        reset_n  = 1'b1;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        do_reset(3, SYNC);

        apply_stimulus(32'h11223344, 8'h44, 0, 0);
        idle(3);

        p0 = rd_pulses;
        drive_byte(8'h00);
        drive_byte(8'hFF);
        drive_byte(8'h5A);
        apply_stimulus(32'h01020304, 8'h04, 0, 0);
        check_output("hunt_rd_pulses", rd_pulses - p0, 64'd9);
        idle(2);

        apply_stimulus(32'h11223344, 8'h00, 0, 1);
        idle(2);

        send_truncated(32'h11000000, 1);
        apply_stimulus(32'hCAFEBABE, xor_of(32'hCAFEBABE), 0, 2);
        idle(2);

        apply_stimulus(32'h0BADF00D, xor_of(32'h0BADF00D), TO - 1, TO - 1);
        send_truncated(rand_word(), NB);
        send_truncated(rand_word(), 0);

        do_reset(2, 8'h00);
        for (int i = 0; i < 5; i++) begin
            w = rand_word();
            apply_stimulus(w, xor_of(w), 0, 0);
        end
        idle(3);

        drive_byte(SYNC);
        drive_byte(8'h11);
        drive_byte(8'h22);
        do_reset(2, 8'h33);
        idle(TO + 5);
        apply_stimulus(32'hA5A5A5A5, 8'h00, 0, 1);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(4, 0));
            w = rand_word();
            case (sel)
                0: send_garbage(int'($urandom_range(4, 1)));
                1: apply_stimulus(w, xor_of(w), 0, 3);
                2: apply_stimulus(w, xor_of(w) ^ 8'($urandom_range(255, 1)), 0, 3);
                3: send_truncated(w, int'($urandom_range(NB, 0)));
                default: apply_stimulus(w, xor_of(w), TO - 5, TO - 1);
            endcase
        end

        idle(TO + 10);
        check_output("scoreboard_drained", sb.size(), 64'd0);
        check_output("rd_uart_total", rd_pulses, bytes_sent);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
